// File: rtl/uplink_arbiter.sv
// Round-robin uplink scheduler: grants one pending slave channel at a time and
// frames its FIFO contents as SYNC / channel / length / payload / XOR checksum.
module uplink_arbiter #(
  parameter int         N_CH      = 5,
  parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
  input  logic              sys_clk,
  input  logic              n_rst,
  input  logic [N_CH-1:0]   have_msg_bus,
  input  logic [8*N_CH-1:0] len_bus,
  input  logic [8*N_CH-1:0] slave_data_bus,
  output logic [N_CH-1:0]   rdreq_bus,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [2:0]        cur_ch
);

  typedef enum logic [2:0] {
    IDLE, SYNC, CHAN, LEN, FETCH, WAIT, PAYLOAD, CSUM
  } state_t;

  state_t     state;
  logic [2:0] last;
  logic [7:0] len_q;
  logic [7:0] csum;
  logic [8:0] cnt;
  logic       xfer;
  logic       grant_vld;
  logic [2:0] grant_ch;
  logic [2:0] cand;
  int         idx;

  logic [7:0] len_arr  [N_CH];
  logic [7:0] data_arr [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign len_arr[gi]  = len_bus[8*gi +: 8];
    assign data_arr[gi] = slave_data_bus[8*gi +: 8];
  end

  assign xfer = tx_valid & tx_ready;
  assign busy = (state != IDLE);

  // Scan from the farthest candidate back to last+1 so the nearest pending channel wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = last;
    idx       = 0;
    cand      = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = 3'(idx);
      if (have_msg_bus[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      last      <= 3'(N_CH - 1);
      cur_ch    <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      rdreq_bus <= '0;
      cnt       <= '0;
    end else begin
      rdreq_bus <= '0;
      case (state)
        IDLE: if (grant_vld) begin
          cur_ch   <= grant_ch;
          last     <= grant_ch;
          tx_data  <= SYNC_BYTE;
          tx_valid <= 1'b1;
          state    <= SYNC;
        end
        SYNC: if (xfer) begin
          tx_data <= {5'b0, cur_ch};
          state   <= CHAN;
        end
        CHAN: if (xfer) begin
          tx_data <= len_q;
          state   <= LEN;
        end
        LEN: if (xfer) begin
          tx_valid          <= 1'b0;
          cnt               <= (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
          rdreq_bus[cur_ch] <= 1'b1;
          state             <= FETCH;
        end
        // rdreq is high during FETCH; the FIFO word is on the bus during WAIT.
        FETCH: state <= WAIT;
        WAIT: begin
          tx_data  <= data_arr[cur_ch];
          tx_valid <= 1'b1;
          state    <= PAYLOAD;
        end
        PAYLOAD: if (xfer) begin
          cnt <= cnt - 9'd1;
          if (cnt == 9'd1) begin
            tx_data <= csum ^ tx_data;
            state   <= CSUM;
          end else begin
            tx_valid          <= 1'b0;
            rdreq_bus[cur_ch] <= 1'b1;
            state             <= FETCH;
          end
        end
        CSUM: if (xfer) begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Length latch and running checksum; always rewritten at grant, so no reset needed.
  always_ff @(posedge sys_clk) begin
    if (state == IDLE && grant_vld) begin
      len_q <= len_arr[grant_ch];
      csum  <= '0;
    end else if (xfer) begin
      case (state)
        CHAN:    csum <= csum ^ {5'b0, cur_ch};
        LEN:     csum <= csum ^ len_q;
        PAYLOAD: csum <= csum ^ tx_data;
        default: ;
      endcase
    end
  end

endmodule
